maj_bist_ctrl: RTL and testbench

Self-test sequencer for the majority-gate implementations (switch-level, NAND/NOT, continuous-assign).
- Drives a shared A/B/C stimulus into N_UNITS majority units.
- Walks all 8 input combinations, waits a programmable settle time per vector, then samples every unit's output against a golden majority.
- Reports pass/fail, a per-unit sticky fail mask, a mismatch count and the first failing vector.
- Sits beside the majority units as their controller. Lets the team run regression on the gate variants without a hand-written timed stimulus bench.

---
 rtl/maj_pkg.sv | 18 +
 rtl/maj_settle_timer.sv | 37 +++
 rtl/maj_bist_ctrl.sv | 168 ++++++++++++++++
 tb/tb_maj_bist_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maj_pkg.sv
// Shared types and helpers for the majority-gate self-test controller.
// Also used by benches that need a golden majority reference.
package maj_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj_settle_timer.sv
// Loadable down-counter with a zero flag.
// It holds a vector steady for a fixed number of cycles.
module maj_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins over decrement; the count saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/maj_bist_ctrl.sv
// Self-test sequencer for majority units: it walks the eight A/B/C vectors and
// compares every unit against a golden majority after a settle delay.
module maj_bist_ctrl
    import maj_pkg::*;
#(
    parameter int N_UNITS       = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               maj_a,
    output logic               maj_b,
    output logic               maj_c,
    input  logic [N_UNITS-1:0] maj_y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               aborted,
    output logic [N_UNITS-1:0] fail_mask,
    output logic [3:0]         err_count,
    output logic [2:0]         first_fail_vec,
    output logic               first_fail_valid
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

    state_e             state_q, state_d;
    logic [2:0]         vec_q, vec_d;
    logic [N_UNITS-1:0] fail_mask_q, fail_mask_d;
    logic [3:0]         err_count_q, err_count_d;
    logic [2:0]         ff_vec_q, ff_vec_d;
    logic               ff_valid_q, ff_valid_d;
    logic               pass_q, pass_d;
    logic               aborted_q, aborted_d;

    logic               timer_load;
    logic               timer_dec;
    logic               timer_zero;
    logic               golden;
    logic [N_UNITS-1:0] mm;

    maj_settle_timer #(
        .W(8)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .load_val_i(SETTLE_LOAD),
        .dec_i     (timer_dec),
        .zero_o    (timer_zero)
    );

    // vec_q doubles as the registered stimulus {A,B,C}
    assign golden = maj3(vec_q[2], vec_q[1], vec_q[0]);
    assign mm     = maj_y ^ {N_UNITS{golden}};

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;
        ff_vec_d    = ff_vec_q;
        ff_valid_d  = ff_valid_q;
        pass_d      = pass_q;
        aborted_d   = aborted_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SETTLE;
                    vec_d       = '0;
                    fail_mask_d = '0;
                    err_count_d = '0;
                    ff_vec_d    = '0;
                    ff_valid_d  = 1'b0;
                    pass_d      = 1'b0;
                    aborted_d   = 1'b0;
                    timer_load  = 1'b1;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d   = IDLE;
                    vec_d     = '0;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (timer_zero) begin
                    state_d = SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            SAMPLE: begin
                // an abort discards the sample taken in the same cycle
                if (abort) begin
                    state_d   = IDLE;
                    vec_d     = '0;
                    aborted_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    fail_mask_d = fail_mask_q | mm;
                    if (|mm) begin
                        err_count_d = err_count_q + 4'd1;
                        if (!ff_valid_q) begin
                            ff_vec_d   = vec_q;
                            ff_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        vec_d   = '0;
                        pass_d  = (err_count_d == 4'd0);
                    end else begin
                        state_d    = SETTLE;
                        vec_d      = vec_q + 3'd1;
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            fail_mask_q <= '0;
            err_count_q <= '0;
            ff_vec_q    <= '0;
            ff_valid_q  <= 1'b0;
            pass_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
            ff_vec_q    <= ff_vec_d;
            ff_valid_q  <= ff_valid_d;
            pass_q      <= pass_d;
            aborted_q   <= aborted_d;
        end
    end

    assign maj_a            = vec_q[2];
    assign maj_b            = vec_q[1];
    assign maj_c            = vec_q[0];
    assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign aborted          = aborted_q;
    assign fail_mask        = fail_mask_q;
    assign err_count        = err_count_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// Directed bench for maj_bist_ctrl with three modelled majority units whose
// behaviour (correct, unit 1 stuck-at-0, unit 2 inverted) is selected by mode.
module tb_maj_bist_ctrl;
    import maj_pkg::*;

    localparam int N_UNITS = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               maj_a, maj_b, maj_c;
    logic [N_UNITS-1:0] maj_y;
    logic               busy, done, pass, aborted;
    logic [N_UNITS-1:0] fail_mask;
    logic [3:0]         err_count;
    logic [2:0]         first_fail_vec;
    logic               first_fail_valid;

    int mode = 0;
    int vectors = 0;
    int miscompares = 0;
    int busy_cnt;
    int done_seen;

    maj_bist_ctrl #(
        .N_UNITS      (N_UNITS),
        .SETTLE_CYCLES(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .maj_a           (maj_a),
        .maj_b           (maj_b),
        .maj_c           (maj_c),
        .maj_y           (maj_y),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .aborted         (aborted),
        .fail_mask       (fail_mask),
        .err_count       (err_count),
        .first_fail_vec  (first_fail_vec),
        .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;

    // units under test
    always_comb begin
        maj_y = {N_UNITS{maj3(maj_a, maj_b, maj_c)}};
        if (mode == 1) maj_y[1] = 1'b0;
        if (mode == 2) maj_y[2] = ~maj3(maj_a, maj_b, maj_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_results(input string tag, input logic pass_e, input logic [2:0] mask_e,
                               input logic [3:0] err_e, input logic ffv_e, input logic [2:0] vec_e);
        chk({tag, "_pass"}, 32'(pass), 32'(pass_e));
        chk({tag, "_mask"}, 32'(fail_mask), 32'(mask_e));
        chk({tag, "_err"}, 32'(err_count), 32'(err_e));
        chk({tag, "_ffvalid"}, 32'(first_fail_valid), 32'(ffv_e));
        if (ffv_e) chk({tag, "_ffvec"}, 32'(first_fail_vec), 32'(vec_e));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        ticks(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stim", 32'({maj_a, maj_b, maj_c}), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk_results("rst", 1'b0, 3'b000, 4'd0, 1'b0, 3'd0);
        rst_n = 1'b1;
        ticks(2);
        chk("idle_busy", 32'(busy), 32'd0);

        // clean run, busy counted over the whole run
        start_pulse();
        chk("r1_busy_e", 32'(busy), 32'd1);
        chk("r1_stim0", 32'({maj_a, maj_b, maj_c}), 32'd0);
        busy_cnt = 1;
        ticks(5);
        chk("r1_stim1", 32'({maj_a, maj_b, maj_c}), 32'd1);
        busy_cnt += 5;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        chk("r1_done_early", 32'(done), 32'd0);
        tick();
        chk("r1_busy_cycles", 32'(busy_cnt), 32'd40);
        chk("r1_done", 32'(done), 32'd1);
        chk("r1_busy_end", 32'(busy), 32'd0);
        chk("r1_stim_end", 32'({maj_a, maj_b, maj_c}), 32'd0);
        chk_results("r1", 1'b1, 3'b000, 4'd0, 1'b0, 3'd0);
        tick();
        chk("r1_done_pulse", 32'(done), 32'd0);
        chk("r1_pass_hold", 32'(pass), 32'd1);

        // unit 1 stuck-at-0
        mode = 1;
        start_pulse();
        chk("r2_pass_cleared", 32'(pass), 32'd0);
        ticks(39);
        tick();
        chk("r2_done", 32'(done), 32'd1);
        chk_results("r2", 1'b0, 3'b010, 4'd4, 1'b1, 3'd3);
        tick();

        // unit 2 inverted
        mode = 2;
        start_pulse();
        chk("r3_cleared", 32'(err_count), 32'd0);
        ticks(40);
        chk("r3_done", 32'(done), 32'd1);
        chk_results("r3", 1'b0, 3'b100, 4'd8, 1'b1, 3'd0);
        tick();

        // abort 20 cycles after start, landing on the sample of vector 011
        mode = 1;
        start_pulse();
        ticks(19);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab1_busy", 32'(busy), 32'd0);
        chk("ab1_aborted", 32'(aborted), 32'd1);
        chk("ab1_done", 32'(done), 32'd0);
        chk("ab1_stim", 32'({maj_a, maj_b, maj_c}), 32'd0);
        chk_results("ab1", 1'b0, 3'b000, 4'd0, 1'b0, 3'd0);

        // abort in SETTLE of vector 100 keeps the failure of 011
        start_pulse();
        chk("ab2_aborted_clr", 32'(aborted), 32'd0);
        ticks(21);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab2_aborted", 32'(aborted), 32'd1);
        chk_results("ab2", 1'b0, 3'b010, 4'd1, 1'b1, 3'd3);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) done_seen++;
        end
        chk("ab2_no_done", 32'(done_seen), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab2_idle_abort", 32'(aborted), 32'd1);

        // clean run after abort; a second start mid-run is ignored
        mode = 0;
        start_pulse();
        chk("r4_aborted_clr", 32'(aborted), 32'd0);
        ticks(9);
        start = 1'b1;
        tick();
        start = 1'b0;
        ticks(29);
        chk("r4_busy39", 32'(busy), 32'd1);
        chk("r4_done_early", 32'(done), 32'd0);
        tick();
        chk("r4_done", 32'(done), 32'd1);
        chk_results("r4", 1'b1, 3'b000, 4'd0, 1'b0, 3'd0);

        // start held high through DONE: next run begins after one IDLE cycle
        mode = 1;
        start = 1'b1;
        tick();
        chk("hold_idle_busy", 32'(busy), 32'd0);
        chk("hold_idle_done", 32'(done), 32'd0);
        tick();
        chk("hold_restart", 32'(busy), 32'd1);
        chk("hold_pass_clr", 32'(pass), 32'd0);
        start = 1'b0;
        ticks(22);
        chk("hold_err", 32'(err_count), 32'd1);
        chk("hold_stim", 32'({maj_a, maj_b, maj_c}), 32'd4);

        // asynchronous reset mid-SETTLE
        #2;
        rst_n = 1'b0;
        #2;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stim", 32'({maj_a, maj_b, maj_c}), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk_results("arst", 1'b0, 3'b000, 4'd0, 1'b0, 3'd0);
        tick();
        rst_n = 1'b1;
        ticks(5);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd1);
        chk("sa_aborted", 32'(aborted), 32'd0);
        ticks(40);
        chk("sa_done", 32'(done), 32'd1);
        chk_results("sa", 1'b0, 3'b010, 4'd4, 1'b1, 3'd3);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
